// File: rtl/image_pack_pkg.sv
// Shared config address and elaboration helpers for the image_pack stream stage.
package image_pack_pkg;

    localparam int unsigned CFG_IP_COUNT = 16;

    // Number of external beats that make up one full-depth pixel word.
    function automatic int unsigned pack_ratio(input int unsigned word_w, input int unsigned beat_w);
        return (beat_w == 0) ? 0 : word_w / beat_w;
    endfunction

    // Lane counter width; kept at one bit when a beat already fills a word.
    function automatic int unsigned lane_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/image_pack_if.sv
// Generic valid/ready stream bundle used on both sides of image_pack.
interface image_pack_if #(
    parameter int unsigned W = 64
) ();
    logic [W-1:0] bus;
    logic         val;
    logic         rdy;

    modport master (output bus, output val, input rdy);
    modport slave  (input bus, input val, output rdy);
endinterface

// File: rtl/image_pack_out.sv
// Single-entry valid/ready output register; a load and an unload may coincide.
module image_pack_out #(
    parameter int unsigned W = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [W-1:0]  i_data,
    image_pack_if.master  o_str
);
    logic         r_val;
    logic [W-1:0] r_data;

    // A new load wins over a transfer, so valid stays high on back-to-back words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_val  <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_val  <= 1'b1;
            r_data <= i_data;
        end else if (r_val && o_str.rdy) begin
            r_val  <= 1'b0;
        end
    end

    assign o_str.val = r_val;
    assign o_str.bus = r_data;
endmodule

// File: rtl/image_pack.sv
// Packs R narrow external beats into one full-depth pixel word per run of cfg_count+1 words.
// Define IMAGE_PACK_SWAP_EN to place the first beat of each word in the MSB slot.
module image_pack
    import image_pack_pkg::*;
#(
    parameter int unsigned CFG_DWIDTH = 32,
    parameter int unsigned CFG_AWIDTH = 5,
    parameter int unsigned DEPTH_NB   = 16,
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned EXT_DWIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_DWIDTH-1:0] cfg_data,
    input  logic [CFG_AWIDTH-1:0] cfg_addr,
    input  logic                  cfg_valid,
    input  logic                  next,
    image_pack_if.slave           ext,
    image_pack_if.master          str_img,
    output logic                  busy
);
    localparam int unsigned WORD_W = IMG_WIDTH * DEPTH_NB;
    localparam int unsigned R      = pack_ratio(WORD_W, EXT_DWIDTH);
    localparam int unsigned LANE_W = lane_width(R);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(R - 1);

    generate
        if ((R == 0) || (R * EXT_DWIDTH != WORD_W)) begin : g_ratio_check
            $error("image_pack: IMG_WIDTH*DEPTH_NB must be a non-zero multiple of EXT_DWIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                r_state;
    logic [LANE_W-1:0]     r_lane;
    logic [CFG_DWIDTH-1:0] r_word_cnt;
    logic [CFG_DWIDTH-1:0] r_word_max;
    logic [CFG_DWIDTH-1:0] r_cfg_count;
    logic [WORD_W-1:0]     r_pack;

    logic                  w_last;
    logic                  w_ext_rdy;
    logic                  w_fire;
    logic                  w_load;
    logic [LANE_W-1:0]     w_slot;
    logic [31:0]           w_base;
    logic [WORD_W-1:0]     w_word;

    // Shadow count; only sampled on a run start, so it carries no reset.
    always_ff @(posedge clk) begin
        if (cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_IP_COUNT))) begin
            r_cfg_count <= cfg_data;
        end
    end

    assign w_last    = (r_lane == LAST_LANE);
    assign w_ext_rdy = (r_state == S_ACTIVE) && (!str_img.val || str_img.rdy || !w_last);
    assign w_fire    = ext.val && w_ext_rdy;
    assign w_load    = w_fire && w_last;
    assign ext.rdy   = w_ext_rdy;
    assign busy      = (r_state != S_IDLE);

`ifdef IMAGE_PACK_SWAP_EN
    assign w_slot = LAST_LANE - r_lane;
`else
    assign w_slot = r_lane;
`endif
    assign w_base = 32'(w_slot) * 32'(EXT_DWIDTH);

    // Partial word with the current beat merged in; this is the word loaded on the last lane.
    always_comb begin
        w_word                          = r_pack;
        w_word[w_base +: EXT_DWIDTH]    = ext.bus;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_lane     <= '0;
            r_word_cnt <= '0;
            r_word_max <= '0;
            r_pack     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (next) begin
                        r_word_max <= r_cfg_count;
                        r_word_cnt <= '0;
                        r_lane     <= '0;
                        r_state    <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_fire) begin
                        r_pack <= w_word;
                        r_lane <= w_last ? '0 : r_lane + 1'b1;
                        // Compare before increment so an all-ones word_max never wraps.
                        if (w_last) begin
                            if (r_word_cnt == r_word_max) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (str_img.val && str_img.rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    image_pack_out #(.W(WORD_W)) u_out (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (w_word),
        .o_str  (str_img)
    );
endmodule

// File: tb/tb_image_pack.sv
// Randomised and directed bench for image_pack against a beat-queue packing model.
module tb_image_pack;
    import image_pack_pkg::*;

    localparam int unsigned EXT_W  = 64;
    localparam int unsigned WORD_W = 256;
    localparam int unsigned R      = WORD_W / EXT_W;

`ifdef IMAGE_PACK_SWAP_EN
    localparam logic [WORD_W-1:0] W0 = {64'd0, 64'd1, 64'd2, 64'd3};
    localparam logic [WORD_W-1:0] W2 = {64'd8, 64'd9, 64'd10, 64'd11};
`else
    localparam logic [WORD_W-1:0] W0 = {64'd3, 64'd2, 64'd1, 64'd0};
    localparam logic [WORD_W-1:0] W2 = {64'd11, 64'd10, 64'd9, 64'd8};
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;
    logic        next;
    logic        busy;

    image_pack_if #(.W(EXT_W))  ext ();
    image_pack_if #(.W(WORD_W)) str_img ();

    image_pack #(
        .CFG_DWIDTH (32),
        .CFG_AWIDTH (5),
        .DEPTH_NB   (16),
        .IMG_WIDTH  (16),
        .EXT_DWIDTH (EXT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_data  (cfg_data),
        .cfg_addr  (cfg_addr),
        .cfg_valid (cfg_valid),
        .next      (next),
        .ext       (ext),
        .str_img   (str_img),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_fail   = 0;

    bit                m_busy = 1'b0;
    bit                m_full = 1'b0;
    logic [31:0]       m_cfg  = 32'd0;
    longint unsigned   m_total = 0;
    longint unsigned   m_beats = 0;
    longint unsigned   m_words_out = 0;
    logic [EXT_W-1:0]  m_cur[$];
    logic [WORD_W-1:0] m_word = '0;
    logic [WORD_W-1:0] got_q[$];
    longint unsigned   fire_cyc_q[$];
    longint unsigned   xfer_cyc_q[$];
    longint unsigned   cyc_n = 0;
    int unsigned       busy_cycles = 0;
    bit                mon_fire = 1'b0;

    bit                mon_xfer;
    bit                mon_load;
    bit                mon_exp_rdy;
    logic [WORD_W-1:0] mon_w;

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: count beats per run, assemble words from a beat queue, track output occupancy.
    always @(negedge clk) begin
        cyc_n++;
        mon_fire = 1'b0;
        if (!rst) begin
            chk("rst_busy",    WORD_W'(busy),        '0);
            chk("rst_str_val", WORD_W'(str_img.val), '0);
            chk("rst_ext_rdy", WORD_W'(ext.rdy),     '0);
            chk("rst_str_bus", str_img.bus,          '0);
            m_busy = 1'b0;
            m_full = 1'b0;
            m_beats = 0;
            m_words_out = 0;
            m_cur.delete();
        end else begin
            mon_exp_rdy = m_busy && (m_beats < 64'(R) * m_total) &&
                          !(m_full && !str_img.rdy && ((m_beats % 64'(R)) == 64'(R - 1)));
            chk("busy",    WORD_W'(busy),        WORD_W'(m_busy));
            chk("str_val", WORD_W'(str_img.val), WORD_W'(m_full));
            chk("ext_rdy", WORD_W'(ext.rdy),     WORD_W'(mon_exp_rdy));
            if (m_full) chk("str_bus", str_img.bus, m_word);
            if (busy) busy_cycles++;

            mon_fire = ext.val && ext.rdy;
            mon_xfer = str_img.val && str_img.rdy;
            mon_load = 1'b0;
            if (mon_xfer) begin
                got_q.push_back(str_img.bus);
                xfer_cyc_q.push_back(cyc_n);
                m_words_out++;
            end
            if (mon_fire) begin
                m_cur.push_back(ext.bus);
                fire_cyc_q.push_back(cyc_n);
                m_beats++;
                if (m_cur.size() == int'(R)) begin
                    mon_w = '0;
                    for (int unsigned k = 0; k < R; k++) begin
`ifdef IMAGE_PACK_SWAP_EN
                        mon_w[(R - 1 - k) * EXT_W +: EXT_W] = m_cur[k];
`else
                        mon_w[k * EXT_W +: EXT_W] = m_cur[k];
`endif
                    end
                    m_word = mon_w;
                    m_cur.delete();
                    mon_load = 1'b1;
                end
            end
            if (mon_load) m_full = 1'b1;
            else if (mon_xfer) m_full = 1'b0;

            if (next && !m_busy) begin
                m_busy = 1'b1;
                m_total = 64'(m_cfg) + 1;
                m_beats = 0;
                m_words_out = 0;
                m_cur.delete();
            end else if (mon_xfer && m_busy && (m_words_out == m_total)) begin
                m_busy = 1'b0;
            end
            if (cfg_valid && (cfg_addr == 5'(CFG_IP_COUNT))) m_cfg = cfg_data;
        end
    end

    task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_next();
        @(posedge clk); #1 next = 1'b1;
        @(posedge clk); #1 next = 1'b0;
    endtask

    function automatic logic [EXT_W-1:0] beat_val(input int mode, input longint unsigned idx);
        if (mode == 2) return {$urandom, $urandom};
        return EXT_W'(idx);
    endfunction

    // mode 0: always valid/ready; 1: stall output 10 cycles after first word; 2: random.
    task automatic drive_run(input logic [31:0] cnt, input bit do_cfg, input int mode,
                             input int unsigned rst_at, input bit mid_next, input int unsigned budget);
        longint unsigned sent = 0;
        int unsigned     cyc = 0;
        int              stall = 0;
        bit              stalled = 1'b0;
        bit              done = 1'b0;
        got_q.delete();
        fire_cyc_q.delete();
        xfer_cyc_q.delete();
        busy_cycles = 0;
        if (do_cfg) begin
            cfg_write(5'(CFG_IP_COUNT + 1), $urandom);
            cfg_write(5'(CFG_IP_COUNT), cnt);
        end
        pulse_next();
        ext.val = 1'b1;
        ext.bus = beat_val(mode, 0);
        str_img.rdy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            if (mon_fire) begin
                sent++;
                ext.bus = beat_val(mode, sent);
            end
            if (!m_busy) begin
                done = 1'b1;
            end else if (cyc > budget) begin
                chk("run_timeout", WORD_W'(cyc), WORD_W'(budget));
                done = 1'b1;
            end else if ((rst_at != 0) && (sent == 64'(rst_at))) begin
                rst = 1'b0;
                #1;
                chk("async_rst_str_val", WORD_W'(str_img.val), '0);
                chk("async_rst_ext_rdy", WORD_W'(ext.rdy),     '0);
                chk("async_rst_busy",    WORD_W'(busy),        '0);
                ext.val = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                done = 1'b1;
            end else begin
                if (mid_next) begin
                    if (cyc == 5) begin
                        cfg_valid = 1'b1;
                        cfg_addr  = 5'(CFG_IP_COUNT);
                        cfg_data  = 32'd5;
                    end else if (cyc == 6) begin
                        cfg_valid = 1'b0;
                        next = 1'b1;
                    end else if (cyc == 7) begin
                        next = 1'b0;
                    end
                end
                if (mode == 1) begin
                    if ((sent == 64'(R)) && !stalled) begin
                        stalled = 1'b1;
                        stall = 10;
                    end
                    if (stall > 0) begin
                        str_img.rdy = 1'b0;
                        stall--;
                    end else begin
                        if (stalled && !str_img.rdy) chk("stall_beats", WORD_W'(m_beats), WORD_W'(R + 3));
                        str_img.rdy = 1'b1;
                    end
                end else if (mode == 2) begin
                    if (!ext.val || mon_fire) ext.val = ($urandom_range(0, 3) != 0);
                    str_img.rdy = ($urandom_range(0, 3) != 0);
                end
            end
        end
        ext.val = 1'b0;
        str_img.rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        next = 1'b0;
        ext.val = 1'b0;
        ext.bus = '0;
        str_img.rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy",    WORD_W'(busy),        '0);
        chk("init_ext_rdy", WORD_W'(ext.rdy),     '0);
        chk("init_str_val", WORD_W'(str_img.val), '0);
        rst = 1'b1;

        // Straight run of three words with indexed beats.
        drive_run(32'd2, 1'b1, 0, 0, 1'b0, 200);
        chk("t1_words", WORD_W'(got_q.size()), WORD_W'(3));
        if (got_q.size() == 3) begin
            chk("t1_word0", got_q[0], W0);
            chk("t1_word2", got_q[2], W2);
        end
        chk("t1_busy_cycles", WORD_W'(busy_cycles), WORD_W'(13));
        if ((fire_cyc_q.size() >= 4) && (xfer_cyc_q.size() >= 1))
            chk("t1_latency", WORD_W'(xfer_cyc_q[0]), WORD_W'(fire_cyc_q[3] + 1));

        // Output stall after the first word.
        drive_run(32'd2, 1'b1, 1, 0, 1'b0, 300);
        chk("t2_words", WORD_W'(got_q.size()), WORD_W'(3));
        if ((fire_cyc_q.size() >= 8) && (xfer_cyc_q.size() >= 1)) begin
            chk("t2_word0", got_q[0], W0);
            chk("t2_release_same_cycle", WORD_W'(fire_cyc_q[7]), WORD_W'(xfer_cyc_q[0]));
        end

        // Random handshakes over 100 words.
        drive_run(32'd99, 1'b1, 2, 0, 1'b0, 5000);
        chk("t3_words", WORD_W'(got_q.size()), WORD_W'(100));
        chk("t3_beats", WORD_W'(fire_cyc_q.size()), WORD_W'(400));

        // Mid-run next and count rewrite; the new count only applies to the following run.
        drive_run(32'd2, 1'b1, 0, 0, 1'b1, 200);
        chk("t4_words_kept", WORD_W'(got_q.size()), WORD_W'(3));
        drive_run(32'd0, 1'b0, 0, 0, 1'b0, 300);
        chk("t4_words_new", WORD_W'(got_q.size()), WORD_W'(6));

        // Reset two beats into the second word, then a clean one-word run.
        drive_run(32'd2, 1'b1, 1, R + 2, 1'b0, 200);
        chk("t5_busy_after_rst", WORD_W'(busy), '0);
        drive_run(32'd0, 1'b1, 0, 0, 1'b0, 100);
        chk("t5_words", WORD_W'(got_q.size()), WORD_W'(1));
        if (got_q.size() == 1) chk("t5_word0", got_q[0], W0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
